// File: rtl/pipe_exe_divider.sv
// EXE-stage radix-2 restoring divider for DIV/DIVU.
// Quotient goes to LO and remainder to HI; stall holds IF/ID and ID/EXE.
`timescale 1ns/1ps
module pipe_exe_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sgn;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_dz;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nx;
    logic             w_neg_q;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept = (r_state == S_IDLE) & start & ~flush;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (flush)             w_next = S_IDLE;
                else if (r_cnt == LAST) w_next = S_FIX;
            end
            S_FIX:  w_next = flush ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    assign stall = reset & (w_accept
                 | (r_state == S_CALC)
                 | (r_state == S_FIX));

    // Operand magnitudes; sign handling only for DIV.
    assign w_neg_a = is_signed & dividend[WIDTH-1];
    assign w_neg_b = is_signed & divisor[WIDTH-1];
    assign w_mag_a = w_neg_a ? -dividend : dividend;
    assign w_mag_b = w_neg_b ? -divisor : divisor;

    // Shifted partial remainder can exceed WIDTH bits before the trial.
    assign w_sh     = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = w_sh >= {1'b0, r_mag_b};
    assign w_diff   = w_sh[WIDTH-1:0] - r_mag_b;
    assign w_rem_nx = w_ge ? w_diff : w_sh[WIDTH-1:0];

    assign w_neg_q = r_sgn & (r_neg_a ^ r_neg_b);
    assign w_q_fix = r_dz ? {WIDTH{1'b1}}
                   : (w_neg_q ? -r_quo : r_quo);
    assign w_r_fix = r_dz ? r_dvd
                   : ((r_sgn & r_neg_a) ? -r_rem : r_rem);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_sgn       <= 1'b0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_dz        <= 1'b0;
            r_dvd       <= '0;
            r_mag_b     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_busy <= (w_next == S_CALC) | (w_next == S_FIX);
            r_done <= (w_next == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sgn   <= is_signed;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_dz    <= (divisor == '0);
                        r_dvd   <= dividend;
                        r_mag_b <= w_mag_b;
                        r_quo   <= w_mag_a;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_rem <= w_rem_nx;
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_pipe_exe_divider.sv
// Scoreboard bench for pipe_exe_divider: timing, signs, div-by-zero,
// overflow, flush, reset and back-to-back issue.
`timescale 1ns/1ps
module tb_pipe_exe_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [31:0] old_q;
    logic [31:0] old_r;

    always #5 clk = ~clk;

    pipe_exe_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sd = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else if (s) begin
            q = sa / sd;
            r = sa % sd;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    always @(negedge clk) begin : mon
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_e = sb.pop_front();
                check("quotient", quotient, exp_e[63:32]);
                check("remainder", remainder, exp_e[31:0]);
            end
        end
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] q,
                          input logic [31:0] r, input bit hold);
        int n;
        @(negedge clk);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        sb.push_back({q, r});
        n = 0;
        #1;
        while (stall && n < 60) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(n), 32'd34);
        check("done_pulse", {31'd0, done}, 32'd1);
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            check("done_single", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] m;

        #2;
        start = 1'b1;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'd2, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rs = 1'($urandom_range(0, 1));
            m = model(ra, rb, rs);
            do_div(ra, rb, rs, m[63:32], m[31:0], 1'b0);
        end

        // Flush in IDLE: no accept, stall drops at once.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        dividend = 32'd77;
        divisor = 32'd7;
        #1;
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        flush = 1'b0;

        // Flush during the 10th CALC cycle.
        old_q = quotient;
        old_r = remainder;
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd3;
        repeat (10) @(negedge clk);
        check("calc_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_q_hold", quotient, old_q);
        check("flush_r_hold", remainder, old_r);
        repeat (40) @(negedge clk);
        check("flush_no_done", {31'd0, done}, 32'd0);
        do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        // Reset asserted mid-CALC.
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd100;
        divisor = 32'd7;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_q", quotient, 32'd0);
        check("mid_rst_r", remainder, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back with start held through DONE.
        do_div(32'd1234, 32'd10, 1'b0, 32'd123, 32'd4, 1'b1);
        do_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_exe_divider.md
Name: pipe_exe_divider

Overview:
- Multi-cycle 32-bit integer divider in the EXE stage, for DIV/DIVU.
- Takes rs/rt operands from the ID/EXE pipeline register and produces quotient (LO) and remainder (HI).
- Drives a stall request that holds the IF/ID and ID/EXE registers (their `we` inputs) until the result is ready.
- Radix-2 restoring algorithm on magnitudes, followed by a sign-fix cycle.

Parameters:
- WIDTH, 32: operand and result width.
- CNT_W, 6: iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  EXE stage holds a DIV/DIVU; level, held by the pipeline while stalled
- is_signed  input  1  1 = DIV, 0 = DIVU; sampled on accept
- flush  input  1  synchronous abort of the instruction in EXE
- dividend  input  WIDTH  rs value; sampled on accept
- divisor  input  WIDTH  rt value; sampled on accept
- stall  output  1  combinational; 1 = freeze upstream pipeline registers
- busy  output  1  registered; 1 in CALC or FIX
- done  output  1  registered; 1 for exactly one cycle (state DONE)
- quotient  output  WIDTH  registered; to LO write path
- remainder  output  WIDTH  registered; to HI write path

Behaviour:
- Reset (reset=0, asynchronous), immediately:
  - state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0.
  - stall is forced 0 while reset is low.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and flush=0, accept on the clock edge: latch is_signed, the operand signs, |dividend| and |divisor| (magnitudes only when is_signed=1), and a divisor-zero flag.
  - Clear the partial remainder; set counter=0; go to CALC.
- CALC, one iteration per edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial subtract the divisor magnitude. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore.
  - counter increments. After the WIDTH-th iteration (counter=WIDTH-1 at that edge), go to FIX.
- FIX, one edge:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative (signed only). The remainder sign always follows the dividend.
  - Divisor-zero override, for both signed and unsigned: quotient=all ones, remainder=original dividend.
  - Load the quotient/remainder outputs; go to DONE.
- DONE:
  - done=1 and results are valid. The next edge always goes to IDLE.
  - start is ignored in DONE, because the same instruction is still in EXE and advances on this edge.
- stall = (IDLE & start & ~flush) | CALC | FIX. It is 0 in DONE, so the instruction leaves EXE on the DONE edge, coincident with the LO/HI write.
- Latency: accept edge, then 32 CALC edges, then 1 FIX edge.
  - stall is high for 34 consecutive cycles.
  - done is high in the 35th cycle counting the accept cycle as 1.
- quotient/remainder hold their value after DONE until the next FIX edge.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (natural wrap, no trap).
- flush=1:
  - In any state, the next edge goes to IDLE, done=0, and outputs hold their previous values.
  - No accept occurs in IDLE on a flush cycle. stall drops combinationally in IDLE and is 0 from the following cycle otherwise.
- Back-to-back: a start present in the IDLE cycle right after DONE is a new instruction and is accepted.
- reset asserted mid-operation: immediate return to the reset values; no partial result is exposed.

Test Plan:
- Unsigned, overall timing: DIVU 100/7.
  - stall high for exactly 34 cycles.
  - done pulses once, with quotient=14 (0x0000000E) and remainder=2.
- Signed, mixed signs: DIV 0xFFFFFFF9 (-7) / 2.
  - quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Divide by zero:
  - DIVU 5/0 gives quotient=0xFFFFFFFF, remainder=5.
  - DIV 0xFFFFFFFB/0 gives quotient=0xFFFFFFFF, remainder=0xFFFFFFFB.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF.
  - quotient=0x80000000, remainder=0.
  - Also DIVU 0xFFFFFFFF/1 gives quotient=0xFFFFFFFF, remainder=0.
- Flush: assert flush during the 10th CALC cycle.
  - busy=0 and stall=0 next cycle; done never pulses; outputs keep their old values.
  - An immediate DIVU 9/3 then gives quotient=3, remainder=0 with full 34-cycle timing.
- Reset and back-to-back:
  - Drive reset low mid-CALC: busy, done, quotient and remainder read 0 immediately.
  - After release, hold start through DONE: the second DIVU 50/5 is accepted in the IDLE cycle after DONE, giving quotient=10, remainder=0. DONE-cycle start does not retrigger.
